// File: rtl/five_bit_adder.sv
// 5-bit ripple-carry adder with carry-in and signed-overflow flag.
// The result is available combinationally and as a one-cycle registered copy.
module five_bit_adder (
   output logic [4:0] sum,
   output logic       cout,
   input  logic       cin,
   input  logic [4:0] i1,
   input  logic [4:0] i2,
   input  logic       clk,
   input  logic       rst_n,
   output logic       ovf,
   output logic [4:0] sum_q,
   output logic       cout_q,
   output logic       ovf_q
);

   // c[k] is the carry into cell k; c[5] is the carry out of the MSB cell
   logic [5:0] c;
   logic [4:0] s;
   logic [4:0] p;
   logic [4:0] g;

   logic [4:0] sum_d;
   logic       cout_d;
   logic       ovf_d;

   // Five chained full-adder cells
   always_comb begin
      c    = '0;
      s    = '0;
      p    = i1 ^ i2;
      g    = i1 & i2;
      c[0] = cin;
      for (int k = 0; k < 5; k++) begin
         s[k]   = p[k] ^ c[k];
         c[k+1] = g[k] | (c[k] & p[k]);
      end
   end

   // Signed overflow: carry into the sign bit disagrees with carry out of it
   assign sum  = s;
   assign cout = c[5];
   assign ovf  = c[4] ^ c[5];

   assign sum_d  = sum;
   assign cout_d = cout;
   assign ovf_d  = ovf;

   // Registered copy; reset clears only these, never the combinational path
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_q  <= 5'b00000;
         cout_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         sum_q  <= sum_d;
         cout_q <= cout_d;
         ovf_q  <= ovf_d;
      end
   end

endmodule

// File: tb/tb_five_bit_adder.sv
// Self-checking bench for five_bit_adder: directed table, exhaustive sweep,
// randomized pipeline stream against an arithmetic reference, and reset corners.
module tb_five_bit_adder;

   logic [4:0] sum;
   logic       cout;
   logic       cin;
   logic [4:0] i1;
   logic [4:0] i2;
   logic       clk;
   logic       rst_n;
   logic       ovf;
   logic [4:0] sum_q;
   logic       cout_q;
   logic       ovf_q;

   int n_cmp;
   int n_fail;

   five_bit_adder dut (
      .sum    (sum),
      .cout   (cout),
      .cin    (cin),
      .i1     (i1),
      .i2     (i2),
      .clk    (clk),
      .rst_n  (rst_n),
      .ovf    (ovf),
      .sum_q  (sum_q),
      .cout_q (cout_q),
      .ovf_q  (ovf_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [4:0] a;
      logic [4:0] b;
      logic       ci;
      logic [4:0] exp_sum;
      logic       exp_cout;
      logic       exp_ovf;
   } vec_t;

   // Reference: plain integer arithmetic, operands reinterpreted as 5-bit signed
   function automatic logic [6:0] ref_model(input int a, input int b, input int ci);
      int total;
      int sa;
      int sb;
      int stot;
      logic [5:0] r;
      logic       o;
      total = a + b + ci;
      sa    = (a >= 16) ? a - 32 : a;
      sb    = (b >= 16) ? b - 32 : b;
      stot  = sa + sb + ci;
      o     = (stot > 15) || (stot < -16);
      r     = 6'(total);
      return {o, r};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   task automatic check_comb(input string name, input logic [4:0] a, input logic [4:0] b, input logic ci);
      logic [6:0] m;
      m = ref_model(int'(a), int'(b), int'(ci));
      check({name, ".sum"},  32'(sum),  32'(m[4:0]));
      check({name, ".cout"}, 32'(cout), 32'(m[5]));
      check({name, ".ovf"},  32'(ovf),  32'(m[6]));
   endtask

   vec_t vecs[6];

   initial begin
      logic [6:0] m;
      logic [6:0] exp_q[$];
      logic [6:0] e;
      int sweep_bad;

      n_cmp  = 0;
      n_fail = 0;
      rst_n  = 1'b0;
      i1 = '0; i2 = '0; cin = 1'b0;

      vecs[0] = '{5'b10101, 5'b10010, 1'b0, 5'b00111, 1'b1, 1'b1};
      vecs[1] = '{5'b11111, 5'b11111, 1'b1, 5'b11111, 1'b1, 1'b0};
      vecs[2] = '{5'b00000, 5'b00000, 1'b1, 5'b00001, 1'b0, 1'b0};
      vecs[3] = '{5'b01111, 5'b00001, 1'b0, 5'b10000, 1'b0, 1'b1};
      vecs[4] = '{5'b11111, 5'b00001, 1'b0, 5'b00000, 1'b1, 1'b0};
      vecs[5] = '{5'b10000, 5'b10000, 1'b0, 5'b00000, 1'b1, 1'b1};

      // Reset state before any clock edge
      #2;
      check("rst.sum_q",  32'(sum_q),  32'd0);
      check("rst.cout_q", 32'(cout_q), 32'd0);
      check("rst.ovf_q",  32'(ovf_q),  32'd0);

      // Directed table, combinational only, while still in reset
      for (int v = 0; v < 6; v++) begin
         i1 = vecs[v].a; i2 = vecs[v].b; cin = vecs[v].ci;
         #1;
         check($sformatf("vec%0d.sum", v),  32'(sum),  32'(vecs[v].exp_sum));
         check($sformatf("vec%0d.cout", v), 32'(cout), 32'(vecs[v].exp_cout));
         check($sformatf("vec%0d.ovf", v),  32'(ovf),  32'(vecs[v].exp_ovf));
         check($sformatf("vec%0d.q_held", v), 32'({sum_q, cout_q, ovf_q}), 32'd0);
      end

      // Exhaustive sweep, counted as one comparison per combination
      for (int a = 0; a < 32; a++) begin
         for (int b = 0; b < 32; b++) begin
            for (int ci = 0; ci < 2; ci++) begin
               i1 = 5'(a); i2 = 5'(b); cin = 1'(ci);
               #1;
               m = ref_model(a, b, ci);
               check($sformatf("sweep_%0d_%0d_%0d", a, b, ci), 32'({ovf, cout, sum}), 32'(m));
            end
         end
      end

      // Release reset between edges, apply case 1, one rising edge
      @(negedge clk);
      rst_n = 1'b1;
      i1 = 5'b10101; i2 = 5'b10010; cin = 1'b0;
      @(posedge clk); #1;
      check("first_cap.sum_q",  32'(sum_q),  32'b00111);
      check("first_cap.cout_q", 32'(cout_q), 32'd1);
      check("first_cap.ovf_q",  32'(ovf_q),  32'd1);

      // Randomized stream: registered outputs lag inputs by exactly one edge
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         i1  = 5'($urandom_range(0, 31));
         i2  = 5'($urandom_range(0, 31));
         cin = 1'($urandom_range(0, 1));
         exp_q.push_back(ref_model(int'(i1), int'(i2), int'(cin)));
         #1;
         check_comb($sformatf("rnd%0d", n), i1, i2, cin);
         @(posedge clk); #1;
         e = exp_q.pop_front();
         check($sformatf("rnd%0d.q", n), 32'({ovf_q, cout_q, sum_q}), 32'(e));
      end

      // Load a non-zero value, then reset asynchronously between edges
      @(negedge clk);
      i1 = 5'b11111; i2 = 5'b11111; cin = 1'b1;
      @(posedge clk); #1;
      check("pre_rst.q", 32'({ovf_q, cout_q, sum_q}), 32'b0111111);
      @(negedge clk); #2;
      rst_n = 1'b0;
      #1;
      check("async_rst.q", 32'({ovf_q, cout_q, sum_q}), 32'd0);
      check_comb("async_rst.comb", i1, i2, cin);
      i1 = 5'b01111; i2 = 5'b00001; cin = 1'b0;
      #1;
      check_comb("in_rst.track", i1, i2, cin);
      @(posedge clk); #1;
      check("in_rst.hold", 32'({ovf_q, cout_q, sum_q}), 32'd0);

      // Release and confirm capture resumes on the next edge
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("post_rst.q", 32'({ovf_q, cout_q, sum_q}), 32'b1010000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
